// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx side signals of the UART transmit arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ack;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_wr;
  logic                    tx_ready;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ack, grant, tx_data, tx_wr
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ack, grant, tx_data, tx_wr
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular sharing of one uart_tx among byte producers
module uart_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus,
  output logic             busy,
  output logic             timeout_err
);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDOG_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT_CYC > 0) ? WDOG_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0  = N_REQ'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;

  logic [2:0]        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d, ack_q, ack_d;
  logic [IDX_W-1:0]  owner_q, owner_d, last_grant_q, last_grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d, last_flag_q, last_flag_d, to_q, to_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [IDX_W-1:0]  pick, cidx;
  logic              found;
  int                c;

  // Cyclic search starting just after the previous owner gives round-robin fairness.
  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    c     = 0;
    cidx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c    = (int'(last_grant_q) + k) % N_REQ;
      cidx = IDX_W'(c);
      if (!found && bus.req_valid[cidx]) begin
        found = 1'b1;
        pick  = cidx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    last_flag_d  = last_flag_q;
    wdog_d       = wdog_q;
    ack_d        = '0;
    wr_d         = 1'b0;
    to_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = ONE_HOT0 << pick;
          owner_d = pick;
          wdog_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.req_valid[owner_q] && bus.tx_ready) begin
          data_d      = bus.req_data[owner_q*DATA_W +: DATA_W];
          wr_d        = 1'b1;
          ack_d       = grant_q;
          last_flag_d = bus.req_last[owner_q];
          wdog_d      = '0;
          state_d     = S_HOLD;
        end else if (!bus.req_valid[owner_q]) begin
          wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
          if (TIMEOUT_CYC != 0 && wdog_q == WDOG_LAST) begin
            to_d         = 1'b1;
            grant_d      = '0;
            last_grant_d = owner_q;
            state_d      = S_IDLE;
          end
        end
      end
      // uart_tx only drops ready a cycle after the strobe, so ready is not trusted here.
      S_HOLD: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.tx_ready) begin
          if (last_flag_q) begin
            grant_d      = '0;
            last_grant_d = owner_q;
            state_d      = S_IDLE;
          end else begin
            wdog_d  = '0;
            state_d = S_GRANT;
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        grant_d      = '0;
        owner_d      = '0;
        last_grant_d = LAST_IDX;
        data_d       = '0;
        last_flag_d  = 1'b0;
        wdog_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= LAST_IDX;
      data_q       <= '0;
      wr_q         <= 1'b0;
      last_flag_q  <= 1'b0;
      to_q         <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      last_flag_q  <= last_flag_d;
      to_q         <= to_d;
      wdog_q       <= wdog_d;
    end
  end

  assign bus.req_ack = ack_q;
  assign bus.grant   = grant_q;
  assign bus.tx_data = data_q;
  assign bus.tx_wr   = wr_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = to_q;
endmodule
